pcie_tag_manager: RTL and testbench

PCIE_TAG_MANAGER -- requirements
Module: pcie_tag_manager

---
 rtl/pcie_tag_manager_if.sv | 29 ++
 rtl/pcie_tag_manager.sv | 88 ++++++++
 tb/tb_pcie_tag_manager.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_tag_manager_if.sv
// Request / completion / status bundle between a requester and the tag manager.
interface pcie_tag_manager_if #(
    parameter int TAG_WIDTH = 5,
    parameter int HDR_WIDTH = 32
);
    logic                 req_valid;
    logic [HDR_WIDTH-1:0] req_hdr;
    logic                 req_ready;
    logic [TAG_WIDTH-1:0] req_tag;
    logic                 cpl_valid;
    logic [TAG_WIDTH-1:0] cpl_tag;
    logic                 cpl_last;
    logic                 flush;
    logic [HDR_WIDTH-1:0] cpl_hdr;
    logic [TAG_WIDTH:0]   outstanding;
    logic                 full;
    logic                 empty;
    logic                 unexp_cpl;

    modport master (
        output req_valid, req_hdr, cpl_valid, cpl_tag, cpl_last, flush,
        input  req_ready, req_tag, cpl_hdr, outstanding, full, empty, unexp_cpl
    );

    modport slave (
        input  req_valid, req_hdr, cpl_valid, cpl_tag, cpl_last, flush,
        output req_ready, req_tag, cpl_hdr, outstanding, full, empty, unexp_cpl
    );
endinterface

// File: rtl/pcie_tag_manager.sv
// Non-posted request tag allocator: grants the lowest free tag, keeps the
// request header per tag, and frees the tag on the final completion.
module pcie_tag_manager #(
    parameter int TAG_WIDTH = 5,
    parameter int HDR_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    pcie_tag_manager_if.slave   bus
);
    localparam int                 NUM_TAGS   = 1 << TAG_WIDTH;
    localparam logic [TAG_WIDTH:0] NUM_TAGS_C = (TAG_WIDTH + 1)'(NUM_TAGS);
    localparam logic [TAG_WIDTH:0] ONE_C      = (TAG_WIDTH + 1)'(1);

    logic [NUM_TAGS-1:0]  busy;
    logic [NUM_TAGS-1:0]  busy_next;
    logic [HDR_WIDTH-1:0] hdr_mem [NUM_TAGS];
    logic [TAG_WIDTH:0]   outstanding_q;
    logic [TAG_WIDTH:0]   outstanding_next;
    logic                 unexp_q;
    logic [TAG_WIDTH-1:0] grant_tag;
    logic                 full_w;
    logic                 alloc;
    logic                 release_hit;
    logic                 unexp_hit;

    // Lowest-index free tag from the registered bitmap only, so a tag freed
    // this cycle cannot be handed out until the next one.
    always_comb begin
        grant_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy[i]) grant_tag = i[TAG_WIDTH-1:0];
        end
    end

    assign full_w      = (outstanding_q == NUM_TAGS_C);
    assign alloc       = bus.req_valid && !full_w;
    assign release_hit = bus.cpl_valid && bus.cpl_last && busy[bus.cpl_tag];
    assign unexp_hit   = bus.cpl_valid && !busy[bus.cpl_tag];

    // Next bitmap: allocation and release always hit different tags, since one
    // picks a clear bit and the other requires a set bit.
    always_comb begin
        busy_next = busy;
        if (alloc)       busy_next[grant_tag]   = 1'b1;
        if (release_hit) busy_next[bus.cpl_tag] = 1'b0;
    end

    // Next outstanding count; a simultaneous allocate and release cancel out.
    always_comb begin
        outstanding_next = outstanding_q;
        case ({alloc, release_hit})
            2'b10:   outstanding_next = outstanding_q + ONE_C;
            2'b01:   outstanding_next = outstanding_q - ONE_C;
            default: outstanding_next = outstanding_q;
        endcase
    end

    // Control state; flush overrides every other same-cycle event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy          <= '0;
            outstanding_q <= '0;
            unexp_q       <= 1'b0;
        end else if (bus.flush) begin
            busy          <= '0;
            outstanding_q <= '0;
            unexp_q       <= 1'b0;
        end else begin
            busy          <= busy_next;
            outstanding_q <= outstanding_next;
            unexp_q       <= unexp_hit;
        end
    end

    // Header store is never cleared; entries of free tags are stale by design.
    always_ff @(posedge clk) begin
        if (alloc && !bus.flush) hdr_mem[grant_tag] <= bus.req_hdr;
    end

    assign bus.req_ready   = !full_w;
    assign bus.req_tag     = grant_tag;
    assign bus.cpl_hdr     = hdr_mem[bus.cpl_tag];
    assign bus.outstanding = outstanding_q;
    assign bus.full        = full_w;
    assign bus.empty       = (outstanding_q == '0);
    assign bus.unexp_cpl   = unexp_q;
endmodule

// File: tb/tb_pcie_tag_manager.sv
// Bench for pcie_tag_manager: directed scenarios plus a random run against a
// bitmap/array reference model.
module tb_pcie_tag_manager;
    localparam int TW = 5;
    localparam int HW = 32;
    localparam int NT = 32;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    pcie_tag_manager_if #(.TAG_WIDTH(TW), .HDR_WIDTH(HW)) bus ();
    pcie_tag_manager #(.TAG_WIDTH(TW), .HDR_WIDTH(HW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    bit          m_busy [NT];
    logic [HW-1:0] m_hdr [NT];
    bit          m_unexp;

    function automatic int m_count();
        int c = 0;
        foreach (m_busy[i]) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic int m_first_free();
        for (int i = 0; i < NT; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_hdr   = '0;
        bus.cpl_valid = 1'b0;
        bus.cpl_tag   = '0;
        bus.cpl_last  = 1'b0;
        bus.flush     = 1'b0;
    endtask

    // Advance one clock, updating the model from the inputs presented before it.
    task automatic cycle();
        bit          n_busy [NT];
        bit          n_unexp;
        int          f;
        int          wr_tag;
        logic [HW-1:0] wr_hdr;
        n_busy  = m_busy;
        n_unexp = 1'b0;
        wr_tag  = -1;
        wr_hdr  = bus.req_hdr;
        if (bus.flush) begin
            foreach (n_busy[i]) n_busy[i] = 1'b0;
        end else begin
            f = m_first_free();
            if (bus.req_valid && f >= 0) begin
                n_busy[f] = 1'b1;
                wr_tag    = f;
            end
            if (bus.cpl_valid) begin
                if (m_busy[bus.cpl_tag]) begin
                    if (bus.cpl_last) n_busy[bus.cpl_tag] = 1'b0;
                end else begin
                    n_unexp = 1'b1;
                end
            end
        end
        @(posedge clk);
        m_busy  = n_busy;
        m_unexp = n_unexp;
        if (wr_tag >= 0) m_hdr[wr_tag] = wr_hdr;
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_unexp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic issue_requests(input int n);
        for (int i = 0; i < n; i++) begin
            bus.req_valid = 1'b1;
            bus.req_hdr   = $urandom;
            cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        n_vec++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.full); end
        n_vec++; if (bus.req_tag !== 5'd0) begin n_err++; $display("FAIL reset_req_tag: got %0d want 0", bus.req_tag); end
        n_vec++; if (bus.outstanding !== 6'd0) begin n_err++; $display("FAIL reset_outstanding: got %0d want 0", bus.outstanding); end
        n_vec++; if (bus.unexp_cpl !== 1'b0) begin n_err++; $display("FAIL reset_unexp: got %b want 0", bus.unexp_cpl); end
    endtask

    task automatic test_back_to_back();
        logic [HW-1:0] h [3];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            h[i] = $urandom;
            bus.req_valid = 1'b1;
            bus.req_hdr   = h[i];
            #1;
            n_vec++; if (bus.req_tag !== TW'(i)) begin n_err++; $display("FAIL b2b_tag%0d: got %0d want %0d", i, bus.req_tag, i); end
            cycle();
        end
        idle_inputs();
        bus.cpl_tag = 5'd1;
        #1;
        n_vec++; if (bus.outstanding !== 6'd3) begin n_err++; $display("FAIL b2b_outstanding: got %0d want 3", bus.outstanding); end
        n_vec++; if (bus.cpl_hdr !== h[1]) begin n_err++; $display("FAIL b2b_cpl_hdr: got %h want %h", bus.cpl_hdr, h[1]); end
        idle_inputs();
    endtask

    task automatic test_fill();
        do_reset();
        issue_requests(NT);
        #1;
        n_vec++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", bus.full); end
        n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready: got %b want 0", bus.req_ready); end
        n_vec++; if (bus.outstanding !== 6'd32) begin n_err++; $display("FAIL fill_outstanding: got %0d want 32", bus.outstanding); end
        bus.req_valid = 1'b1;
        bus.req_hdr   = $urandom;
        bus.cpl_valid = 1'b1;
        bus.cpl_tag   = 5'd7;
        bus.cpl_last  = 1'b1;
        cycle();
        idle_inputs();
        #1;
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL fill_release_ready: got %b want 1", bus.req_ready); end
        n_vec++; if (bus.req_tag !== 5'd7) begin n_err++; $display("FAIL fill_release_tag: got %0d want 7", bus.req_tag); end
        n_vec++; if (bus.outstanding !== 6'd31) begin n_err++; $display("FAIL fill_release_outstanding: got %0d want 31", bus.outstanding); end
    endtask

    task automatic test_partial_cpl();
        do_reset();
        issue_requests(4);
        bus.cpl_valid = 1'b1;
        bus.cpl_tag   = 5'd2;
        bus.cpl_last  = 1'b0;
        cycle();
        #1;
        n_vec++; if (bus.outstanding !== 6'd4) begin n_err++; $display("FAIL partial_outstanding: got %0d want 4", bus.outstanding); end
        n_vec++; if (bus.req_tag !== 5'd4) begin n_err++; $display("FAIL partial_tag: got %0d want 4", bus.req_tag); end
        n_vec++; if (bus.unexp_cpl !== 1'b0) begin n_err++; $display("FAIL partial_unexp: got %b want 0", bus.unexp_cpl); end
        bus.cpl_last = 1'b1;
        cycle();
        idle_inputs();
        #1;
        n_vec++; if (bus.outstanding !== 6'd3) begin n_err++; $display("FAIL last_outstanding: got %0d want 3", bus.outstanding); end
        n_vec++; if (bus.req_tag !== 5'd2) begin n_err++; $display("FAIL last_tag: got %0d want 2", bus.req_tag); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        issue_requests(4);
        bus.req_valid = 1'b1;
        bus.req_hdr   = $urandom;
        bus.cpl_valid = 1'b1;
        bus.cpl_tag   = 5'd1;
        bus.cpl_last  = 1'b1;
        #1;
        n_vec++; if (bus.req_tag !== 5'd4) begin n_err++; $display("FAIL same_grant: got %0d want 4", bus.req_tag); end
        cycle();
        idle_inputs();
        #1;
        n_vec++; if (bus.outstanding !== 6'd4) begin n_err++; $display("FAIL same_outstanding: got %0d want 4", bus.outstanding); end
        n_vec++; if (bus.req_tag !== 5'd1) begin n_err++; $display("FAIL same_next_tag: got %0d want 1", bus.req_tag); end
        issue_requests(1);
        #1;
        n_vec++; if (bus.outstanding !== 6'd5) begin n_err++; $display("FAIL same_after_outstanding: got %0d want 5", bus.outstanding); end
        n_vec++; if (bus.req_tag !== 5'd5) begin n_err++; $display("FAIL same_after_tag: got %0d want 5", bus.req_tag); end
    endtask

    task automatic test_unexpected();
        do_reset();
        issue_requests(2);
        bus.cpl_valid = 1'b1;
        bus.cpl_tag   = 5'd9;
        bus.cpl_last  = 1'b1;
        cycle();
        idle_inputs();
        #1;
        n_vec++; if (bus.unexp_cpl !== 1'b1) begin n_err++; $display("FAIL unexp_pulse: got %b want 1", bus.unexp_cpl); end
        n_vec++; if (bus.outstanding !== 6'd2) begin n_err++; $display("FAIL unexp_outstanding: got %0d want 2", bus.outstanding); end
        cycle();
        #1;
        n_vec++; if (bus.unexp_cpl !== 1'b0) begin n_err++; $display("FAIL unexp_width: got %b want 0", bus.unexp_cpl); end
        n_vec++; if (bus.req_tag !== 5'd2) begin n_err++; $display("FAIL unexp_tag: got %0d want 2", bus.req_tag); end
    endtask

    task automatic test_flush();
        do_reset();
        issue_requests(5);
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_hdr   = $urandom;
        bus.cpl_valid = 1'b1;
        bus.cpl_tag   = 5'd20;
        bus.cpl_last  = 1'b1;
        cycle();
        idle_inputs();
        #1;
        n_vec++; if (bus.outstanding !== 6'd0) begin n_err++; $display("FAIL flush_outstanding: got %0d want 0", bus.outstanding); end
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL flush_empty: got %b want 1", bus.empty); end
        n_vec++; if (bus.unexp_cpl !== 1'b0) begin n_err++; $display("FAIL flush_unexp: got %b want 0", bus.unexp_cpl); end
        n_vec++; if (bus.req_tag !== 5'd0) begin n_err++; $display("FAIL flush_tag: got %0d want 0", bus.req_tag); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        issue_requests(6);
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++; if (bus.outstanding !== 6'd0) begin n_err++; $display("FAIL midrst_outstanding: got %0d want 0", bus.outstanding); end
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", bus.req_ready); end
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_unexp = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_hdr   = $urandom;
        #1;
        n_vec++; if (bus.req_tag !== 5'd0) begin n_err++; $display("FAIL midrst_first_tag: got %0d want 0", bus.req_tag); end
        cycle();
        idle_inputs();
        #1;
        n_vec++; if (bus.outstanding !== 6'd1) begin n_err++; $display("FAIL midrst_after: got %0d want 1", bus.outstanding); end
    endtask

    task automatic test_random();
        int cnt;
        int ff;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.req_valid = ($urandom_range(0, 99) < 60);
            bus.req_hdr   = $urandom;
            bus.cpl_valid = ($urandom_range(0, 99) < 50);
            bus.cpl_tag   = TW'($urandom_range(0, NT - 1));
            bus.cpl_last  = ($urandom_range(0, 99) < 70);
            bus.flush     = ($urandom_range(0, 999) < 15);
            #1;
            cnt = m_count();
            ff  = m_first_free();
            n_vec++; if (bus.outstanding !== 6'(cnt)) begin n_err++; $display("FAIL rnd_outstanding c%0d: got %0d want %0d", c, bus.outstanding, cnt); end
            n_vec++; if (bus.req_ready !== (cnt < NT)) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.req_ready, cnt < NT); end
            n_vec++; if (bus.full !== (cnt == NT)) begin n_err++; $display("FAIL rnd_full c%0d: got %b want %b", c, bus.full, cnt == NT); end
            n_vec++; if (bus.empty !== (cnt == 0)) begin n_err++; $display("FAIL rnd_empty c%0d: got %b want %b", c, bus.empty, cnt == 0); end
            n_vec++; if (bus.unexp_cpl !== m_unexp) begin n_err++; $display("FAIL rnd_unexp c%0d: got %b want %b", c, bus.unexp_cpl, m_unexp); end
            if (ff >= 0) begin
                n_vec++; if (bus.req_tag !== TW'(ff)) begin n_err++; $display("FAIL rnd_tag c%0d: got %0d want %0d", c, bus.req_tag, ff); end
            end
            if (m_busy[bus.cpl_tag]) begin
                n_vec++; if (bus.cpl_hdr !== m_hdr[bus.cpl_tag]) begin n_err++; $display("FAIL rnd_cpl_hdr c%0d: got %h want %h", c, bus.cpl_hdr, m_hdr[bus.cpl_tag]); end
            end
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_fill();
        test_partial_cpl();
        test_same_cycle();
        test_unexpected();
        test_flush();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
